forwarding_scoreboard: RTL and testbench

- Parametrised successor to the EX-stage forwarding unit.
- Tracks the destination register of every in-flight instruction across DEPTH pipeline slots and generates registered per-operand forward selects for N_SRC source operands.
- Detects load-use hazards for any load latency, stalls ID and inserts bubbles.
- Keeps a saturating stall-cycle counter.
- Sits between the ID stage and the ID/EX pipeline register; mux select outputs feed the EX operand muxes.

---
 rtl/forwarding_scoreboard.sv | 94 +++++++++
 tb/tb_forwarding_scoreboard.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/forwarding_scoreboard.sv
// Forwarding scoreboard: tracks in-flight destinations, registers EX
// operand forward selects and stalls ID on load-use hazards.
module forwarding_scoreboard #(
  parameter int REG_AW    = 5,
  parameter int N_SRC     = 2,
  parameter int DEPTH     = 3,
  parameter int LOAD_DIST = 2,
  parameter int ZERO_REG  = 1,
  localparam int SELW     = $clog2(DEPTH + 1)
) (
  input  logic                    Clk,
  input  logic                    Reset,
  input  logic                    issue_valid,
  input  logic [REG_AW-1:0]       issue_rd,
  input  logic                    issue_regwrite,
  input  logic                    issue_load,
  input  logic [N_SRC-1:0]        src_valid,
  input  logic [N_SRC*REG_AW-1:0] src_reg,
  input  logic                    flush,
  output logic                    stall,
  output logic                    issue_accept,
  output logic [N_SRC*SELW-1:0]   fwd_sel,
  output logic [15:0]             stall_count
);

  logic [DEPTH:1]    v;
  logic [DEPTH:1]    rw;
  logic [DEPTH:1]    ld;
  logic [REG_AW-1:0] rd [DEPTH:1];

  logic [SELW-1:0]   m [N_SRC];
  logic [N_SRC-1:0]  haz;

  // Youngest matching slot per operand and its load-use hazard.
  always_comb begin
    for (int i = 0; i < N_SRC; i++) begin
      m[i]   = '0;
      haz[i] = 1'b0;
      for (int k = DEPTH; k >= 1; k--) begin
        if (src_valid[i] && v[k] && rw[k] &&
            rd[k] == src_reg[i*REG_AW +: REG_AW] &&
            !(ZERO_REG != 0 &&
              src_reg[i*REG_AW +: REG_AW] == '0)) begin
          m[i]   = SELW'(k);
          haz[i] = ld[k] && (k < LOAD_DIST);
        end
      end
    end
  end

  assign stall        = issue_valid & ~flush & (|haz);
  assign issue_accept = issue_valid & ~stall & ~flush;

  // Slot shift register: always advances, bubble when nothing issues.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      v  <= '0;
      rw <= '0;
      ld <= '0;
      for (int k = 1; k <= DEPTH; k++) rd[k] <= '0;
    end else begin
      v[1]  <= issue_accept;
      rw[1] <= issue_accept & issue_regwrite;
      ld[1] <= issue_accept & issue_load;
      rd[1] <= issue_accept ? issue_rd : '0;
      for (int k = 2; k <= DEPTH; k++) begin
        v[k]  <= v[k-1];
        rw[k] <= rw[k-1];
        ld[k] <= ld[k-1];
        rd[k] <= rd[k-1];
      end
    end
  end

  // Forward selects travel with the instruction into ID/EX.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      fwd_sel <= '0;
    end else begin
      for (int i = 0; i < N_SRC; i++)
        fwd_sel[i*SELW +: SELW] <= issue_accept ? m[i] : '0;
    end
  end

  // Saturating count of stalled cycles.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      stall_count <= '0;
    end else if (stall && stall_count != 16'hFFFF) begin
      stall_count <= stall_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_forwarding_scoreboard.sv
// Bench for forwarding_scoreboard: default, deep (5/4) and
// saturation (7/7) instances share one stimulus bus.
module tb_forwarding_scoreboard;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       iv = 1'b0;
  logic [4:0] rd = '0;
  logic       rw = 1'b0;
  logic       ld = 1'b0;
  logic [1:0] sv = '0;
  logic [9:0] sr = '0;
  logic       fl = 1'b0;

  logic        stall0, stall1, stall2;
  logic        acc0, acc1, acc2;
  logic [3:0]  fwd0;
  logic [5:0]  fwd1, fwd2;
  logic [15:0] cnt0, cnt1, cnt2;

  logic        st [3];
  logic        ac [3];
  logic [7:0]  fw [3];
  logic [15:0] sc [3];

  int checks = 0;
  int errors = 0;
  logic [7:0] q [$];

  always #5 clk = ~clk;

  forwarding_scoreboard u0 (
    .Clk(clk), .Reset(rst), .issue_valid(iv), .issue_rd(rd),
    .issue_regwrite(rw), .issue_load(ld), .src_valid(sv),
    .src_reg(sr), .flush(fl), .stall(stall0),
    .issue_accept(acc0), .fwd_sel(fwd0), .stall_count(cnt0)
  );

  forwarding_scoreboard #(.DEPTH(5), .LOAD_DIST(4)) u1 (
    .Clk(clk), .Reset(rst), .issue_valid(iv), .issue_rd(rd),
    .issue_regwrite(rw), .issue_load(ld), .src_valid(sv),
    .src_reg(sr), .flush(fl), .stall(stall1),
    .issue_accept(acc1), .fwd_sel(fwd1), .stall_count(cnt1)
  );

  forwarding_scoreboard #(.DEPTH(7), .LOAD_DIST(7)) u2 (
    .Clk(clk), .Reset(rst), .issue_valid(iv), .issue_rd(rd),
    .issue_regwrite(rw), .issue_load(ld), .src_valid(sv),
    .src_reg(sr), .flush(fl), .stall(stall2),
    .issue_accept(acc2), .fwd_sel(fwd2), .stall_count(cnt2)
  );

  assign st[0] = stall0;
  assign st[1] = stall1;
  assign st[2] = stall2;
  assign ac[0] = acc0;
  assign ac[1] = acc1;
  assign ac[2] = acc2;
  assign fw[0] = {4'b0, fwd0};
  assign fw[1] = {2'b0, fwd1};
  assign fw[2] = {2'b0, fwd2};
  assign sc[0] = cnt0;
  assign sc[1] = cnt1;
  assign sc[2] = cnt2;

  task automatic chk(string tag, logic [31:0] got,
                     logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic do_rst();
    @(negedge clk);
    rst = 1'b1;
    iv  = 1'b0;
    fl  = 1'b0;
    sv  = '0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Drive one ID cycle, check stall/accept now, fwd_sel after edge.
  task automatic step(string tag, int u, logic p_iv,
                      logic [4:0] p_rd, logic p_rw, logic p_ld,
                      logic [1:0] p_sv, logic [4:0] p_a,
                      logic [4:0] p_b, logic p_fl, logic es,
                      logic ea, logic [7:0] ef);
    @(negedge clk);
    iv = p_iv;
    rd = p_rd;
    rw = p_rw;
    ld = p_ld;
    sv = p_sv;
    sr = {p_b, p_a};
    fl = p_fl;
    #1;
    chk({tag, ".stall"}, 32'(st[u]), 32'(es));
    chk({tag, ".acc"}, 32'(ac[u]), 32'(ea));
    q.push_back(ef);
    @(posedge clk);
    #1;
    chk({tag, ".fwd"}, 32'(fw[u]), 32'(q.pop_front()));
  endtask

  initial begin
    // ALU chain
    do_rst();
    chk("rst.fwd", 32'(fw[0]), 0);
    chk("rst.cnt", 32'(sc[0]), 0);
    chk("rst.stall", 32'(st[0]), 0);
    step("c1.add", 0, 1, 3, 1, 0, 0, 0, 0, 0, 0, 1, 8'h0);
    step("c1.sub", 0, 1, 5, 1, 0, 3, 3, 3, 0, 0, 1, 8'h5);
    step("c2.add", 0, 1, 3, 1, 0, 0, 0, 0, 0, 0, 1, 8'h0);
    step("c2.x", 0, 1, 9, 1, 0, 0, 0, 0, 0, 0, 1, 8'h0);
    step("c2.sub", 0, 1, 5, 1, 0, 1, 3, 1, 0, 0, 1, 8'h2);
    step("c3.add", 0, 1, 3, 1, 0, 0, 0, 0, 0, 0, 1, 8'h0);
    step("c3.x1", 0, 1, 9, 1, 0, 0, 0, 0, 0, 0, 1, 8'h0);
    step("c3.x2", 0, 1, 9, 1, 0, 0, 0, 0, 0, 0, 1, 8'h0);
    step("c3.x3", 0, 1, 9, 1, 0, 0, 0, 0, 0, 0, 1, 8'h0);
    step("c3.sub", 0, 1, 5, 1, 0, 1, 3, 1, 0, 0, 1, 8'h0);
    step("idle", 0, 0, 5, 1, 0, 3, 5, 5, 0, 0, 0, 8'h0);

    // Load-use
    do_rst();
    step("lu.lw", 0, 1, 4, 1, 1, 0, 0, 0, 0, 0, 1, 8'h0);
    step("lu.st", 0, 1, 6, 1, 0, 3, 4, 1, 0, 1, 0, 8'h0);
    step("lu.go", 0, 1, 6, 1, 0, 3, 4, 1, 0, 0, 1, 8'h2);
    chk("lu.cnt", 32'(sc[0]), 1);

    // Youngest producer wins
    do_rst();
    step("yw.add", 0, 1, 7, 1, 0, 0, 0, 0, 0, 0, 1, 8'h0);
    step("yw.lw", 0, 1, 7, 1, 1, 0, 0, 0, 0, 0, 1, 8'h0);
    step("yw.st", 0, 1, 8, 1, 0, 3, 7, 0, 0, 1, 0, 8'h0);
    step("yw.go", 0, 1, 8, 1, 0, 3, 7, 0, 0, 0, 1, 8'h2);
    chk("yw.cnt", 32'(sc[0]), 1);
    step("r0.lw", 0, 1, 0, 1, 1, 0, 0, 0, 0, 0, 1, 8'h0);
    step("r0.use", 0, 1, 8, 1, 0, 3, 0, 0, 0, 0, 1, 8'h0);

    // Flush and unused operands
    do_rst();
    step("fl.lw", 0, 1, 4, 1, 1, 0, 0, 0, 0, 0, 1, 8'h0);
    step("fl.fl", 0, 1, 6, 1, 0, 3, 4, 4, 1, 0, 0, 8'h0);
    step("fl.go", 0, 1, 6, 1, 0, 3, 4, 4, 0, 0, 1, 8'hA);
    chk("fl.cnt", 32'(sc[0]), 0);
    do_rst();
    step("sv.lw", 0, 1, 4, 1, 1, 0, 0, 0, 0, 0, 1, 8'h0);
    step("sv.use", 0, 1, 6, 1, 0, 0, 4, 4, 0, 0, 1, 8'h0);

    // Reset mid-stall
    do_rst();
    step("rs.lw", 0, 1, 4, 1, 1, 0, 0, 0, 0, 0, 1, 8'h0);
    @(negedge clk);
    iv = 1'b1;
    rd = 5'd6;
    rw = 1'b1;
    ld = 1'b0;
    sv = 2'b01;
    sr = {5'd0, 5'd4};
    rst = 1'b1;
    #1;
    chk("rs.pre", 32'(st[0]), 1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rs.cnt", 32'(sc[0]), 0);
    chk("rs.fwd", 32'(fw[0]), 0);
    step("rs.use", 0, 1, 6, 1, 0, 1, 4, 0, 0, 0, 1, 8'h0);

    // Deep instance: 3-cycle load-use stall
    do_rst();
    step("d.lw", 1, 1, 4, 1, 1, 0, 0, 0, 0, 0, 1, 8'h0);
    step("d.s1", 1, 1, 6, 1, 0, 1, 4, 0, 0, 1, 0, 8'h0);
    step("d.s2", 1, 1, 6, 1, 0, 1, 4, 0, 0, 1, 0, 8'h0);
    step("d.s3", 1, 1, 6, 1, 0, 1, 4, 0, 0, 1, 0, 8'h0);
    step("d.go", 1, 1, 6, 1, 0, 1, 4, 0, 0, 0, 1, 8'h4);
    chk("d.cnt", 32'(sc[1]), 3);

    // Saturation: self-dependent load, 6 stalls per 7 cycles
    do_rst();
    @(negedge clk);
    iv = 1'b1;
    rd = 5'd4;
    rw = 1'b1;
    ld = 1'b1;
    sv = 2'b01;
    sr = {5'd0, 5'd4};
    fl = 1'b0;
    repeat (700) @(posedge clk);
    #1;
    chk("sat.mid", 32'(sc[2]), 600);
    repeat (75800) @(posedge clk);
    #1;
    chk("sat.end", 32'(sc[2]), 32'hFFFF);
    repeat (10) @(posedge clk);
    #1;
    chk("sat.hold", 32'(sc[2]), 32'hFFFF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
